hazard_scoreboard: RTL and testbench

Parametrised forwarding and hazard unit for the RV32I pipeline, sitting beside the ID stage. For every ID source operand it picks the youngest forwarding stage holding that register. It tracks in-flight long-latency writes (load miss, mul/div) in a tagged scoreboard, and raises a pipeline stall for load-use, RAW-on-pending and WAW-on-pending hazards. It also keeps a saturating stall-cycle counter.

---
 rtl/hazard_scoreboard_if.sv | 55 +++++
 rtl/hazard_scoreboard.sv | 129 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// Bundle between the ID-stage hazard logic and the rest of the pipeline.
// master drives ID/forward/long-latency inputs; slave is the hazard unit.
interface hazard_scoreboard_if #(
    parameter int REGFILE_ADDR_WIDTH = 5,
    parameter int NUM_RD_PORTS       = 2,
    parameter int NUM_FWD_STAGES     = 2,
    parameter int LL_DEPTH           = 4,
    parameter int STAT_WIDTH         = 16
);
    localparam int AW     = REGFILE_ADDR_WIDTH;
    localparam int FSEL_W = $clog2(NUM_FWD_STAGES + 1);
    localparam int TAG_W  = (LL_DEPTH > 1) ? $clog2(LL_DEPTH) : 1;

    logic                         ID_valid;
    logic [NUM_RD_PORTS*AW-1:0]   ID_Rs_addr;
    logic [NUM_RD_PORTS-1:0]      ID_Rs_used;
    logic [AW-1:0]                ID_Rd_addr;
    logic                         ID_RegFile_wr_en;
    logic [NUM_FWD_STAGES*AW-1:0] Fwd_Rd_addr;
    logic [NUM_FWD_STAGES-1:0]    Fwd_RegFile_wr_en;
    logic [NUM_FWD_STAGES-1:0]    Fwd_data_ready;
    logic [NUM_RD_PORTS*FSEL_W-1:0] Forward_sel;
    logic                         Stall;
    logic                         LL_issue;
    logic [AW-1:0]                LL_Rd_addr;
    logic                         LL_ready;
    logic [TAG_W-1:0]             LL_tag;
    logic                         LL_done;
    logic [TAG_W-1:0]             LL_done_tag;
    logic                         Stat_clr;
    logic [STAT_WIDTH-1:0]        Stall_cycles;
    logic                         Err;

    modport master (
        output ID_valid, ID_Rs_addr, ID_Rs_used,
        output ID_Rd_addr, ID_RegFile_wr_en,
        output Fwd_Rd_addr, Fwd_RegFile_wr_en,
        output Fwd_data_ready,
        output LL_issue, LL_Rd_addr,
        output LL_done, LL_done_tag, Stat_clr,
        input  Forward_sel, Stall, LL_ready,
        input  LL_tag, Stall_cycles, Err
    );

    modport slave (
        input  ID_valid, ID_Rs_addr, ID_Rs_used,
        input  ID_Rd_addr, ID_RegFile_wr_en,
        input  Fwd_Rd_addr, Fwd_RegFile_wr_en,
        input  Fwd_data_ready,
        input  LL_issue, LL_Rd_addr,
        input  LL_done, LL_done_tag, Stat_clr,
        output Forward_sel, Stall, LL_ready,
        output LL_tag, Stall_cycles, Err
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Forwarding select, long-latency scoreboard and stall generation for ID.
// Ports: Clk, Rst_n (async low), bus (slave: ID/fwd/LL/stat signals).
module hazard_scoreboard #(
    parameter int REGFILE_ADDR_WIDTH = 5,
    parameter int NUM_RD_PORTS       = 2,
    parameter int NUM_FWD_STAGES     = 2,
    parameter int LL_DEPTH           = 4,
    parameter int STAT_WIDTH         = 16
) (
    input  logic               Clk,
    input  logic               Rst_n,
    hazard_scoreboard_if.slave bus
);
    localparam int AW     = REGFILE_ADDR_WIDTH;
    localparam int NRP    = NUM_RD_PORTS;
    localparam int NFS    = NUM_FWD_STAGES;
    localparam int FSEL_W = $clog2(NFS + 1);
    localparam int TAG_W  = (LL_DEPTH > 1) ? $clog2(LL_DEPTH) : 1;

    logic [LL_DEPTH-1:0]     vld_q;
    logic [AW-1:0]           rd_q [LL_DEPTH];
    logic [STAT_WIDTH-1:0]   cnt_q;
    logic                    err_q;

    logic [NRP*FSEL_W-1:0]   fsel;
    logic [AW-1:0]           rs;
    logic [AW-1:0]           fa;
    logic [FSEL_W-1:0]       sel;
    logic                    sel_rdy;
    logic                    load_use;
    logic                    raw;
    logic                    waw;
    logic                    stall;
    logic                    ll_ready;
    logic [TAG_W-1:0]        ll_tag;

    // Stages are scanned oldest-first so the youngest match overwrites.
    always_comb begin
        fsel     = '0;
        load_use = 1'b0;
        rs       = '0;
        fa       = '0;
        sel      = '0;
        sel_rdy  = 1'b0;
        for (int p = 0; p < NRP; p++) begin
            rs      = bus.ID_Rs_addr[p*AW +: AW];
            sel     = '0;
            sel_rdy = 1'b0;
            for (int s = NFS; s >= 1; s--) begin
                fa = bus.Fwd_Rd_addr[(s-1)*AW +: AW];
                if (bus.Fwd_RegFile_wr_en[s-1] &&
                    fa != '0 && fa == rs) begin
                    sel     = FSEL_W'(s);
                    sel_rdy = bus.Fwd_data_ready[s-1];
                end
            end
            fsel[p*FSEL_W +: FSEL_W] = sel;
            if (bus.ID_Rs_used[p] && sel != '0 && !sel_rdy)
                load_use = 1'b1;
        end
    end

    always_comb begin
        raw = 1'b0;
        waw = 1'b0;
        for (int e = 0; e < LL_DEPTH; e++) begin
            for (int p = 0; p < NRP; p++) begin
                if (bus.ID_Rs_used[p] && vld_q[e] &&
                    bus.ID_Rs_addr[p*AW +: AW] != '0 &&
                    rd_q[e] == bus.ID_Rs_addr[p*AW +: AW])
                    raw = 1'b1;
            end
            if (bus.ID_RegFile_wr_en && vld_q[e] &&
                bus.ID_Rd_addr != '0 &&
                rd_q[e] == bus.ID_Rd_addr)
                waw = 1'b1;
        end
    end

    // Lowest free entry wins; tag reads 0 when the table is full.
    always_comb begin
        ll_ready = ~&vld_q;
        ll_tag   = '0;
        for (int e = LL_DEPTH - 1; e >= 0; e--) begin
            if (!vld_q[e])
                ll_tag = TAG_W'(e);
        end
    end

    assign stall = bus.ID_valid & (load_use | raw | waw);

    // Done and issue cannot target the same live entry: issue only
    // uses a free slot, and a done to a free slot is ignored.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            vld_q <= '0;
            err_q <= 1'b0;
            cnt_q <= '0;
            for (int e = 0; e < LL_DEPTH; e++)
                rd_q[e] <= '0;
        end else begin
            if (bus.LL_done) begin
                if (vld_q[bus.LL_done_tag])
                    vld_q[bus.LL_done_tag] <= 1'b0;
                else
                    err_q <= 1'b1;
            end
            if (bus.LL_issue) begin
                if (ll_ready) begin
                    vld_q[ll_tag] <= 1'b1;
                    rd_q[ll_tag]  <= bus.LL_Rd_addr;
                end else begin
                    err_q <= 1'b1;
                end
            end
            if (bus.Stat_clr)
                cnt_q <= '0;
            else if (stall && cnt_q != '1)
                cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.Forward_sel  = fsel;
    assign bus.Stall        = stall;
    assign bus.LL_ready     = ll_ready;
    assign bus.LL_tag       = ll_tag;
    assign bus.Stall_cycles = cnt_q;
    assign bus.Err          = err_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard.
// Drives at negedge, samples combinational #1 later or #1 after posedge.
module tb_hazard_scoreboard;
    logic Clk = 1'b0;
    logic Rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    hazard_scoreboard_if bus ();

    hazard_scoreboard dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus.slave)
    );

    always #5 Clk = ~Clk;

    task automatic idle();
        bus.ID_valid          = 1'b0;
        bus.ID_Rs_addr        = '0;
        bus.ID_Rs_used        = '0;
        bus.ID_Rd_addr        = '0;
        bus.ID_RegFile_wr_en  = 1'b0;
        bus.Fwd_Rd_addr       = '0;
        bus.Fwd_RegFile_wr_en = '0;
        bus.Fwd_data_ready    = '0;
        bus.LL_issue          = 1'b0;
        bus.LL_Rd_addr        = '0;
        bus.LL_done           = 1'b0;
        bus.LL_done_tag       = '0;
        bus.Stat_clr          = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        idle();
        Rst_n = 1'b0;
        #1;
        chk("rst_ll_ready", 32'(bus.LL_ready), 32'd1);
        chk("rst_ll_tag", 32'(bus.LL_tag), 32'd0);
        chk("rst_stall", 32'(bus.Stall), 32'd0);
        chk("rst_cnt", 32'(bus.Stall_cycles), 32'd0);
        chk("rst_err", 32'(bus.Err), 32'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
    endtask

    task automatic test_forward();
        @(negedge Clk);
        idle();
        bus.ID_valid          = 1'b1;
        bus.Fwd_Rd_addr       = {5'd5, 5'd5};
        bus.Fwd_RegFile_wr_en = 2'b11;
        bus.Fwd_data_ready    = 2'b11;
        bus.ID_Rs_addr        = {5'd0, 5'd5};
        bus.ID_Rs_used        = 2'b01;
        #1;
        chk("fwd_both", 32'(bus.Forward_sel), 32'h1);
        chk("fwd_both_stall", 32'(bus.Stall), 32'd0);
        bus.Fwd_RegFile_wr_en = 2'b10;
        #1;
        chk("fwd_stage2", 32'(bus.Forward_sel), 32'h2);
        bus.ID_Rs_addr = {5'd5, 5'd0};
        #1;
        chk("fwd_port1", 32'(bus.Forward_sel), 32'h8);
        bus.Fwd_Rd_addr       = {5'd0, 5'd0};
        bus.Fwd_RegFile_wr_en = 2'b11;
        bus.ID_Rs_addr        = {5'd0, 5'd0};
        #1;
        chk("fwd_x0", 32'(bus.Forward_sel), 32'h0);
        chk("fwd_x0_stall", 32'(bus.Stall), 32'd0);
    endtask

    task automatic test_load_use();
        @(negedge Clk);
        idle();
        bus.ID_valid          = 1'b1;
        bus.Fwd_Rd_addr       = {5'd0, 5'd7};
        bus.Fwd_RegFile_wr_en = 2'b01;
        bus.Fwd_data_ready    = 2'b10;
        bus.ID_Rs_addr        = {5'd7, 5'd0};
        bus.ID_Rs_used        = 2'b10;
        #1;
        chk("lu_stall", 32'(bus.Stall), 32'd1);
        chk("lu_sel", 32'(bus.Forward_sel), 32'h4);
        chk("lu_cnt_before", 32'(bus.Stall_cycles), 32'd0);
        @(posedge Clk);
        #1;
        chk("lu_cnt_after", 32'(bus.Stall_cycles), 32'd1);
        @(negedge Clk);
        bus.ID_Rs_used = 2'b00;
        #1;
        chk("lu_unused", 32'(bus.Stall), 32'd0);
        bus.ID_Rs_used = 2'b10;
        bus.ID_valid   = 1'b0;
        #1;
        chk("lu_invalid", 32'(bus.Stall), 32'd0);
        @(posedge Clk);
        #1;
        chk("lu_cnt_hold", 32'(bus.Stall_cycles), 32'd1);
    endtask

    task automatic test_scoreboard();
        @(negedge Clk);
        idle();
        bus.LL_issue   = 1'b1;
        bus.LL_Rd_addr = 5'd9;
        #1;
        chk("sb_tag0", 32'(bus.LL_tag), 32'd0);
        chk("sb_ready", 32'(bus.LL_ready), 32'd1);
        @(negedge Clk);
        idle();
        bus.ID_valid   = 1'b1;
        bus.ID_Rs_addr = {5'd0, 5'd9};
        bus.ID_Rs_used = 2'b01;
        #1;
        chk("sb_raw", 32'(bus.Stall), 32'd1);
        chk("sb_next_tag", 32'(bus.LL_tag), 32'd1);
        bus.ID_Rs_used       = 2'b00;
        bus.ID_Rd_addr       = 5'd9;
        bus.ID_RegFile_wr_en = 1'b1;
        #1;
        chk("sb_waw", 32'(bus.Stall), 32'd1);
        bus.ID_RegFile_wr_en = 1'b0;
        bus.ID_Rs_used       = 2'b01;
        bus.LL_done          = 1'b1;
        bus.LL_done_tag      = 2'd0;
        #1;
        chk("sb_done_same", 32'(bus.Stall), 32'd1);
        @(negedge Clk);
        bus.LL_done = 1'b0;
        #1;
        chk("sb_done_next", 32'(bus.Stall), 32'd0);
        chk("sb_free_tag", 32'(bus.LL_tag), 32'd0);
        chk("sb_err", 32'(bus.Err), 32'd0);
    endtask

    task automatic test_full_error();
        logic [4:0] rds [4];
        rds[0] = 5'd0;
        rds[1] = 5'd10;
        rds[2] = 5'd11;
        rds[3] = 5'd12;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            idle();
            bus.LL_issue   = 1'b1;
            bus.LL_Rd_addr = rds[i];
            #1;
            chk($sformatf("full_tag%0d", i), 32'(bus.LL_tag), 32'(i));
            chk($sformatf("full_rdy%0d", i), 32'(bus.LL_ready), 32'd1);
        end
        @(negedge Clk);
        idle();
        #1;
        chk("full_ready0", 32'(bus.LL_ready), 32'd0);
        chk("full_tag_full", 32'(bus.LL_tag), 32'd0);
        @(negedge Clk);
        bus.LL_issue   = 1'b1;
        bus.LL_Rd_addr = 5'd13;
        #1;
        chk("full_err_pre", 32'(bus.Err), 32'd0);
        @(negedge Clk);
        idle();
        #1;
        chk("full_err", 32'(bus.Err), 32'd1);
        bus.ID_valid   = 1'b1;
        bus.ID_Rs_used = 2'b01;
        bus.ID_Rs_addr = {5'd0, 5'd13};
        #1;
        chk("full_rejected", 32'(bus.Stall), 32'd0);
        bus.ID_Rs_addr = {5'd0, 5'd10};
        #1;
        chk("full_pend10", 32'(bus.Stall), 32'd1);
        bus.ID_Rs_addr = {5'd0, 5'd0};
        #1;
        chk("full_x0", 32'(bus.Stall), 32'd0);
        @(negedge Clk);
        idle();
        bus.LL_issue    = 1'b1;
        bus.LL_Rd_addr  = 5'd14;
        bus.LL_done     = 1'b1;
        bus.LL_done_tag = 2'd2;
        #1;
        chk("full_done_rdy", 32'(bus.LL_ready), 32'd0);
        @(negedge Clk);
        idle();
        #1;
        chk("full_after_rdy", 32'(bus.LL_ready), 32'd1);
        chk("full_after_tag", 32'(bus.LL_tag), 32'd2);
        bus.ID_valid   = 1'b1;
        bus.ID_Rs_used = 2'b01;
        bus.ID_Rs_addr = {5'd0, 5'd14};
        #1;
        chk("full_x14", 32'(bus.Stall), 32'd0);
        bus.ID_Rs_addr = {5'd0, 5'd11};
        #1;
        chk("full_freed11", 32'(bus.Stall), 32'd0);
        bus.ID_Rs_addr = {5'd0, 5'd12};
        #1;
        chk("full_pend12", 32'(bus.Stall), 32'd1);
    endtask

    task automatic test_saturation();
        @(negedge Clk);
        idle();
        bus.ID_valid          = 1'b1;
        bus.Fwd_Rd_addr       = {5'd0, 5'd7};
        bus.Fwd_RegFile_wr_en = 2'b01;
        bus.ID_Rs_addr        = {5'd0, 5'd7};
        bus.ID_Rs_used        = 2'b01;
        bus.Stat_clr          = 1'b1;
        @(posedge Clk);
        #1;
        chk("sat_clr_wins", 32'(bus.Stall_cycles), 32'd0);
        @(negedge Clk);
        bus.Stat_clr = 1'b0;
        repeat (65534) @(posedge Clk);
        #1;
        chk("sat_fffe", 32'(bus.Stall_cycles), 32'hFFFE);
        repeat (7) @(posedge Clk);
        #1;
        chk("sat_ffff", 32'(bus.Stall_cycles), 32'hFFFF);
        @(negedge Clk);
        bus.Stat_clr = 1'b1;
        @(posedge Clk);
        #1;
        chk("sat_clear", 32'(bus.Stall_cycles), 32'd0);
        @(negedge Clk);
        idle();
    endtask

    task automatic test_async_reset();
        @(negedge Clk);
        idle();
        bus.ID_valid   = 1'b1;
        bus.ID_Rs_used = 2'b01;
        bus.ID_Rs_addr = {5'd0, 5'd10};
        #1;
        chk("ar_pre_stall", 32'(bus.Stall), 32'd1);
        chk("ar_pre_err", 32'(bus.Err), 32'd1);
        #1;
        Rst_n = 1'b0;
        #1;
        chk("ar_ready", 32'(bus.LL_ready), 32'd1);
        chk("ar_tag", 32'(bus.LL_tag), 32'd0);
        chk("ar_err", 32'(bus.Err), 32'd0);
        chk("ar_stall", 32'(bus.Stall), 32'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        @(posedge Clk);
        #1;
        chk("ar_post_stall", 32'(bus.Stall), 32'd0);
        @(negedge Clk);
        idle();
        bus.LL_done     = 1'b1;
        bus.LL_done_tag = 2'd1;
        @(negedge Clk);
        idle();
        #1;
        chk("ar_bad_done_err", 32'(bus.Err), 32'd1);
        chk("ar_bad_done_rdy", 32'(bus.LL_tag), 32'd0);
    endtask

    initial begin
        idle();
        test_reset();
        test_forward();
        test_load_use();
        test_scoreboard();
        test_full_error();
        test_saturation();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
